// File: rtl/async_fifo_pkg.sv
// Gray-code helpers shared by the dual-clock FIFO; callers size-cast to their pointer width.
`timescale 1ns/1ps
package async_fifo_pkg;

    localparam int GRAY_MAX_W = 32;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Zero-extended inputs convert correctly because leading zero Gray bits stay zero.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W-2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for Gray-coded pointers crossing into the destination clock domain.
`timescale 1ns/1ps
module sync_2ff #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_p0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_p0 <= '0;
            q       <= '0;
        end else begin
            meta_p0 <= d;
            q       <= meta_p0;
        end
    end

endmodule

// File: rtl/async_fifo.sv
// Dual-clock FIFO: Gray pointers cross domains through two-flop synchronizers,
// full is derived in the write domain and empty in the read domain.
`timescale 1ns/1ps
module async_fifo
    import async_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                  wr_clk,
    input  logic                  rd_clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  vaild_out,
    output logic                  empty
);

    localparam int PW = ADDR_WIDTH + 1;
    // Full when the write pointer has lapped the read pointer: top two Gray bits differ.
    localparam logic [PW-1:0] FULL_MASK = {2'b11, {(ADDR_WIDTH-1){1'b0}}};

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wbin, wgray, wbin_next, wgray_next, wq2_rgray;
    logic [PW-1:0] rbin, rgray, rbin_next, rgray_next, rq2_wgray;
    logic          wr_inc, rd_inc, full_next, empty_next;

    // Write domain
    always_comb begin
        wr_inc     = wr_en && !full;
        wbin_next  = wbin + PW'(wr_inc);
        wgray_next = PW'(bin2gray(GRAY_MAX_W'(wbin_next)));
        full_next  = (wgray_next == (wq2_rgray ^ FULL_MASK));
    end

    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            wbin  <= '0;
            wgray <= '0;
            full  <= 1'b0;
        end else begin
            wbin  <= wbin_next;
            wgray <= wgray_next;
            full  <= full_next;
        end
    end

    always_ff @(posedge wr_clk) begin
        if (wr_inc) begin
            mem[wbin[ADDR_WIDTH-1:0]] <= din;
        end
    end

    // Read domain
    always_comb begin
        rd_inc     = rd_en && !empty;
        rbin_next  = rbin + PW'(rd_inc);
        rgray_next = PW'(bin2gray(GRAY_MAX_W'(rbin_next)));
        empty_next = (rgray_next == rq2_wgray);
    end

    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            rbin      <= '0;
            rgray     <= '0;
            empty     <= 1'b1;
            vaild_out <= 1'b0;
            dout      <= '0;
        end else begin
            rbin      <= rbin_next;
            rgray     <= rgray_next;
            empty     <= empty_next;
            vaild_out <= rd_inc;
            if (rd_inc) begin
                dout <= mem[rbin[ADDR_WIDTH-1:0]];
            end
        end
    end

    // Clock-domain crossings: only Gray-coded pointers pass between domains
    sync_2ff #(.WIDTH(PW)) u_sync_w2r (
        .clk (rd_clk),
        .rst (rst),
        .d   (wgray),
        .q   (rq2_wgray)
    );

    sync_2ff #(.WIDTH(PW)) u_sync_r2w (
        .clk (wr_clk),
        .rst (rst),
        .d   (rgray),
        .q   (wq2_rgray)
    );

endmodule

// File: tb/tb_async_fifo.sv
// Directed bench for async_fifo: reset, single word, fill/overflow, random stream, underflow, mid-stream reset.
`timescale 1ns/1ps
module tb_async_fifo;

    logic       wr_clk = 1'b0;
    logic       rd_clk = 1'b0;
    logic       rst    = 1'b1;
    logic       wr_en  = 1'b0;
    logic       rd_en  = 1'b0;
    logic [7:0] din    = 8'h00;
    logic [7:0] dout;
    logic       full, empty, vaild_out;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] last_word = 8'h00;
    logic [7:0] sb [$];

    async_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16)) dut (
        .wr_clk    (wr_clk),
        .rd_clk    (rd_clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .din       (din),
        .full      (full),
        .rd_en     (rd_en),
        .dout      (dout),
        .vaild_out (vaild_out),
        .empty     (empty)
    );

    initial forever #5 wr_clk = ~wr_clk;
    initial begin
        #3;
        forever #10 rd_clk = ~rd_clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wr_push(input logic [7:0] d);
        @(negedge wr_clk);
        din   = d;
        wr_en = 1'b1;
        @(posedge wr_clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic rd_pop();
        @(negedge rd_clk);
        rd_en = 1'b1;
        @(posedge rd_clk);
        #1;
        rd_en = 1'b0;
    endtask

    task automatic wait_data(input string name);
        int c = 0;
        while (empty && c < 8) begin
            @(posedge rd_clk);
            #1;
            c++;
        end
        total++;
        if (empty !== 1'b0) begin
            bad++;
            $display("FAIL %s_not_empty: empty=%b required 0 after %0d rd cycles", name, empty, c);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #10;
        wr_en = 1'b1;
        din   = 8'h77;
        rd_en = 1'b1;
        #20;
        wr_en = 1'b0;
        rd_en = 1'b0;
        #20;
        total++; if (empty !== 1'b1)     begin bad++; $display("FAIL reset_empty: got %b required 1", empty); end
        total++; if (full !== 1'b0)      begin bad++; $display("FAIL reset_full: got %b required 0", full); end
        total++; if (vaild_out !== 1'b0) begin bad++; $display("FAIL reset_vaild: got %b required 0", vaild_out); end
        total++; if (dout !== 8'h00)     begin bad++; $display("FAIL reset_dout: got %h required 00", dout); end
        @(posedge wr_clk);
        #2;
        rst = 1'b0;
        repeat (5) @(posedge rd_clk);
        #1;
        total++; if (empty !== 1'b1)     begin bad++; $display("FAIL post_reset_empty: got %b required 1", empty); end
        total++; if (full !== 1'b0)      begin bad++; $display("FAIL post_reset_full: got %b required 0", full); end
        total++; if (vaild_out !== 1'b0) begin bad++; $display("FAIL post_reset_vaild: got %b required 0", vaild_out); end
    endtask

    task automatic test_single();
        wr_push(8'hA5);
        wait_data("single");
        rd_pop();
        total++; if (vaild_out !== 1'b1) begin bad++; $display("FAIL single_vaild: got %b required 1", vaild_out); end
        total++; if (dout !== 8'hA5)     begin bad++; $display("FAIL single_dout: got %h required a5", dout); end
        total++; if (empty !== 1'b1)     begin bad++; $display("FAIL single_empty_after: got %b required 1", empty); end
        @(posedge rd_clk);
        #1;
        total++; if (vaild_out !== 1'b0) begin bad++; $display("FAIL single_vaild_drop: got %b required 0", vaild_out); end
        total++; if (dout !== 8'hA5)     begin bad++; $display("FAIL single_dout_hold: got %h required a5", dout); end
        last_word = 8'hA5;
    endtask

    task automatic test_fill();
        logic [7:0] exp;
        for (int i = 0; i < 16; i++) begin
            wr_push(8'(8'h30 + i * 7));
            if (i == 14) begin
                total++; if (full !== 1'b0) begin bad++; $display("FAIL fill_full_15: got %b required 0", full); end
            end
        end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full_16: got %b required 1", full); end
        wr_push(8'hFF);
        total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full_17: got %b required 1", full); end
        wait_data("fill");
        for (int i = 0; i < 16; i++) begin
            exp = 8'(8'h30 + i * 7);
            rd_pop();
            total++;
            if (vaild_out !== 1'b1 || dout !== exp) begin
                bad++;
                $display("FAIL fill_read_%0d: vaild=%b dout=%h required vaild=1 dout=%h", i, vaild_out, dout, exp);
            end
            last_word = exp;
        end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL fill_empty_after: got %b required 1", empty); end
        rd_pop();
        total++; if (vaild_out !== 1'b0) begin bad++; $display("FAIL fill_dropped_word: vaild=%b dout=%h required vaild=0", vaild_out, dout); end
    endtask

    task automatic test_stream();
        sb.delete();
        fork
            begin
                int n = 0;
                int cyc = 0;
                while (n < 100 && cyc < 5000) begin
                    @(negedge wr_clk);
                    if (!full) begin
                        din   = 8'($urandom_range(0, 255));
                        wr_en = 1'b1;
                        sb.push_back(din);
                        n++;
                    end else begin
                        wr_en = 1'b0;
                    end
                    cyc++;
                end
                @(negedge wr_clk);
                wr_en = 1'b0;
            end
            begin
                int got = 0;
                int cyc = 0;
                logic [7:0] exp;
                while (got < 100 && cyc < 3000) begin
                    @(negedge rd_clk);
                    rd_en = !empty;
                    @(posedge rd_clk);
                    #1;
                    if (vaild_out) begin
                        exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
                        total++;
                        if (dout !== exp) begin
                            bad++;
                            $display("FAIL stream_beat_%0d: dout=%h required %h", got, dout, exp);
                        end
                        last_word = exp;
                        got++;
                    end
                    cyc++;
                end
                rd_en = 1'b0;
                total++;
                if (got != 100) begin
                    bad++;
                    $display("FAIL stream_count: got %0d words required 100", got);
                end
            end
        join
        total++; if (sb.size() != 0) begin bad++; $display("FAIL stream_leftover: %0d words left required 0", sb.size()); end
    endtask

    task automatic test_underflow();
        for (int i = 0; i < 5; i++) begin
            @(negedge rd_clk);
            rd_en = 1'b1;
            @(posedge rd_clk);
            #1;
            total++;
            if (vaild_out !== 1'b0 || dout !== last_word) begin
                bad++;
                $display("FAIL underflow_%0d: vaild=%b dout=%h required vaild=0 dout=%h", i, vaild_out, dout, last_word);
            end
        end
        rd_en = 1'b0;
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL underflow_empty: got %b required 1", empty); end
        wr_push(8'h5A);
        wait_data("underflow");
        rd_pop();
        total++;
        if (vaild_out !== 1'b1 || dout !== 8'h5A) begin
            bad++;
            $display("FAIL underflow_recover: vaild=%b dout=%h required vaild=1 dout=5a", vaild_out, dout);
        end
    endtask

    task automatic test_midreset();
        for (int i = 0; i < 8; i++) wr_push(8'(8'hC0 + i));
        #3;
        rst = 1'b1;
        #30;
        total++; if (empty !== 1'b1)     begin bad++; $display("FAIL midrst_empty: got %b required 1", empty); end
        total++; if (full !== 1'b0)      begin bad++; $display("FAIL midrst_full: got %b required 0", full); end
        total++; if (vaild_out !== 1'b0) begin bad++; $display("FAIL midrst_vaild: got %b required 0", vaild_out); end
        total++; if (dout !== 8'h00)     begin bad++; $display("FAIL midrst_dout: got %h required 00", dout); end
        @(posedge wr_clk);
        #2;
        rst = 1'b0;
        repeat (4) @(posedge rd_clk);
        #1;
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL midrst_empty_after: got %b required 1", empty); end
        wr_push(8'h3C);
        wait_data("midrst");
        rd_pop();
        total++;
        if (vaild_out !== 1'b1 || dout !== 8'h3C) begin
            bad++;
            $display("FAIL midrst_readback: vaild=%b dout=%h required vaild=1 dout=3c", vaild_out, dout);
        end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL midrst_empty_final: got %b required 1", empty); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_underflow();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
